// File: rtl/synchronizer_2ff.sv
// Multi-flop synchronizer for a WIDTH-bit bus entering the clk domain.
// Intended for Gray-coded pointers, where at most one bit changes per source update.
module synchronizer_2ff #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  generate
    if (STAGES < 2) begin : g_bad_stages
      $error("synchronizer_2ff: STAGES must be >= 2");
    end
    if (WIDTH < 1) begin : g_bad_width
      $error("synchronizer_2ff: WIDTH must be >= 1");
    end
  endgenerate

  // Stage 0 is the metastability-catching flop; the stages are kept adjacent and never retimed.
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s <= '0;
    end else begin
      s <= {s[STAGES-2:0], data_in};
    end
  end

  assign data_out = s[STAGES-1];

endmodule

// File: tb/tb_synchronizer_2ff.sv
// Directed bench for synchronizer_2ff: a default 4-bit/2-stage instance and an
// 8-bit/3-stage instance, checked with a vector table and hand-written sequences.
module tb_synchronizer_2ff;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic [3:0] dout;
  logic       rst8;
  logic [7:0] din8;
  logic [7:0] dout8;

  int vectors;
  int miscompares;

  synchronizer_2ff dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (din),
    .data_out (dout)
  );

  synchronizer_2ff #(.WIDTH(8), .STAGES(3)) dut8 (
    .clk      (clk),
    .rst      (rst8),
    .data_in  (din8),
    .data_out (dout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] din;
    logic [3:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edge_then_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  vec_t tbl[$];

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Steps from a cleared pipeline: step 3->C, Gray walk, then a mid-stream reset.
    tbl.push_back('{1'b1, 4'h3, 4'h0});
    tbl.push_back('{1'b1, 4'h3, 4'h3});
    tbl.push_back('{1'b1, 4'hC, 4'h3});
    tbl.push_back('{1'b1, 4'hC, 4'hC});
    tbl.push_back('{1'b1, 4'h0, 4'hC});
    tbl.push_back('{1'b1, 4'h1, 4'h0});
    tbl.push_back('{1'b1, 4'h3, 4'h1});
    tbl.push_back('{1'b1, 4'h2, 4'h3});
    tbl.push_back('{1'b1, 4'h6, 4'h2});
    tbl.push_back('{1'b1, 4'h7, 4'h6});
    tbl.push_back('{1'b1, 4'h5, 4'h7});
    tbl.push_back('{1'b1, 4'h4, 4'h5});
    tbl.push_back('{1'b1, 4'h4, 4'h4});
    tbl.push_back('{1'b1, 4'h4, 4'h4});
    tbl.push_back('{1'b0, 4'h9, 4'h0});
    tbl.push_back('{1'b1, 4'h9, 4'h0});
    tbl.push_back('{1'b1, 4'h9, 4'h9});
    tbl.push_back('{1'b1, 4'h6, 4'h9});
    tbl.push_back('{1'b1, 4'h6, 4'h6});

    // Reset hold with data_in all ones.
    rst  = 1'b0;
    din  = 4'hF;
    rst8 = 1'b0;
    din8 = 8'h00;
    #1;
    check("reset_initial", {4'h0, dout}, 8'h00);
    for (int i = 0; i < 3; i++) begin
      edge_then_settle();
      check("reset_hold_edge", {4'h0, dout}, 8'h00);
      @(negedge clk);
      check("reset_hold_mid", {4'h0, dout}, 8'h00);
    end

    // Release before an edge: two-edge latency, then stays put.
    rst = 1'b1;
    edge_then_settle();
    check("latency_edge1", {4'h0, dout}, 8'h00);
    edge_then_settle();
    check("latency_edge2", {4'h0, dout}, 8'h0F);
    for (int i = 0; i < 20; i++) begin
      edge_then_settle();
      check("stable_hold", {4'h0, dout}, 8'h0F);
    end

    // Asynchronous reset between edges, then refill.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_clear_immediate", {4'h0, dout}, 8'h00);
    edge_then_settle();
    check("async_clear_held", {4'h0, dout}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    edge_then_settle();
    check("refill_edge1", {4'h0, dout}, 8'h00);
    edge_then_settle();
    check("refill_edge2", {4'h0, dout}, 8'h0F);

    // Clear the pipeline before the table.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("pre_table_clear", {4'h0, dout}, 8'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].rst;
      din = tbl[i].din;
      edge_then_settle();
      check($sformatf("table[%0d]", i), {4'h0, dout}, {4'h0, tbl[i].exp});
    end

    // Three-stage, 8-bit instance: A5 appears on the third edge.
    @(negedge clk);
    din8 = 8'hA5;
    #1;
    check("w8_in_reset", dout8, 8'h00);
    @(negedge clk);
    rst8 = 1'b1;
    edge_then_settle();
    check("w8_edge1", dout8, 8'h00);
    edge_then_settle();
    check("w8_edge2", dout8, 8'h00);
    edge_then_settle();
    check("w8_edge3", dout8, 8'hA5);
    edge_then_settle();
    check("w8_hold", dout8, 8'hA5);
    @(negedge clk);
    rst8 = 1'b0;
    #1;
    check("w8_async_clear", dout8, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
